header_inserter: RTL and testbench

- Upstream counterpart of the header-stripping stage: prepends a constant-size header to each payload packet on an Avalon-ST stream.
- Accepts a HEADER_SIZE-bit header on a side port, emits it as HEADER_WORDS data words (most-significant word first), then passes the payload packet through unchanged up to and including eop.
- Output is a single packet whose sop sits on the first header word.

---
 rtl/header_inserter_if.sv | 30 +++
 rtl/header_inserter.sv | 130 +++++++++++++
 tb/tb_header_inserter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/header_inserter_if.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_if
// Description : Avalon-ST stream bundle (data, valid, ready, sop, eop, empty)
//               with source (master) and sink (slave) modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (
        output data, valid, sop, eop, empty,
        input  ready
    );

    modport slave (
        input  data, valid, sop, eop, empty,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/header_inserter.sv
`default_nettype none
// ============================================================================
// Module      : header_inserter
// Description : Prepends a HEADER_SIZE-bit header (MSB word first) to each
//               Avalon-ST payload packet. Optional HEADER_INSERTER_PKT_CNT_EN
//               adds a 16-bit wrapping count of forwarded packets.
// Revision    : 1.0 - initial release
// ============================================================================
module header_inserter #(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HEADER_SIZE-1:0] header_data,
    input  logic                   header_valid,
    output logic                   header_ready,
    avalon_st_if.slave             data_in,
    avalon_st_if.master            data_out
`ifdef HEADER_INSERTER_PKT_CNT_EN
    ,
    output logic [15:0]            pkt_count
`endif
);

    localparam int HEADER_WORDS = HEADER_SIZE / DATA_WIDTH;
    localparam int CNT_W        = $clog2(HEADER_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(HEADER_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HEADER_ST = 2'd1,
        DATA_ST   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [HEADER_SIZE-1:0] hdr_q, hdr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef HEADER_INSERTER_PKT_CNT_EN
    logic [15:0]            pkt_cnt_q, pkt_cnt_d;
`endif

    // Incoming sop is redundant: the header already marks the packet start.
    logic unused_sop;
    assign unused_sop = data_in.sop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            cnt_q     <= '0;
`ifdef HEADER_INSERTER_PKT_CNT_EN
            pkt_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            cnt_q     <= cnt_d;
`ifdef HEADER_INSERTER_PKT_CNT_EN
            pkt_cnt_q <= pkt_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        cnt_d          = cnt_q;
`ifdef HEADER_INSERTER_PKT_CNT_EN
        pkt_cnt_d      = pkt_cnt_q;
`endif
        header_ready   = 1'b0;
        data_in.ready  = 1'b0;
        data_out.valid = 1'b0;
        data_out.data  = '0;
        data_out.sop   = 1'b0;
        data_out.eop   = 1'b0;
        data_out.empty = '0;

        case (state_q)
            IDLE: begin
                header_ready = ~rst;
                if (header_valid) begin
                    hdr_d   = header_data;
                    cnt_d   = '0;
                    state_d = HEADER_ST;
                end
            end

            HEADER_ST: begin
                // Header register shifts left per accepted word, so the
                // outgoing word is always its top slice straight from flops.
                data_out.valid = 1'b1;
                data_out.data  = hdr_q[HEADER_SIZE-1 -: DATA_WIDTH];
                data_out.sop   = (cnt_q == '0);
                if (data_out.ready) begin
                    hdr_d = hdr_q << DATA_WIDTH;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = DATA_ST;
                    end
                end
            end

            DATA_ST: begin
                data_out.valid = data_in.valid;
                data_out.data  = data_in.data;
                data_out.eop   = data_in.eop;
                data_out.empty = data_in.empty;
                data_in.ready  = data_out.ready;
                if (data_in.valid && data_out.ready && data_in.eop) begin
                    state_d = IDLE;
`ifdef HEADER_INSERTER_PKT_CNT_EN
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef HEADER_INSERTER_PKT_CNT_EN
    assign pkt_count = pkt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_header_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_header_inserter
// Description : Self-checking bench for header_inserter: directed packets plus
//               randomized traffic against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_header_inserter;

    localparam int DW   = 128;
    localparam int HS   = 256;
    localparam int HW   = HS / DW;
    localparam int NPK  = 40;
    localparam int MAXP = 4;
    localparam int TMO  = 500;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [3:0]    empty;
        logic [31:0]   cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [HS-1:0] header_data = '0;
    logic          header_valid = 1'b0;
    logic          header_ready;
`ifdef HEADER_INSERTER_PKT_CNT_EN
    logic [15:0]   pkt_count;
`endif

    avalon_st_if #(.DATA_WIDTH(DW)) s_in ();
    avalon_st_if #(.DATA_WIDTH(DW)) s_out ();

    header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
        .clk          (clk),
        .rst          (rst),
        .header_data  (header_data),
        .header_valid (header_valid),
        .header_ready (header_ready),
        .data_in      (s_in),
        .data_out     (s_out)
`ifdef HEADER_INSERTER_PKT_CNT_EN
        ,
        .pkt_count    (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] cycle      = 0;

    logic [HS-1:0] hdr  [NPK];
    logic [DW-1:0] pay  [NPK][MAXP];
    logic [3:0]    pemp [NPK][MAXP];
    int            plen [NPK];

    beat_t expq [$];
    beat_t logq [$];
    int    hs_cyc [$];

    int    ready_mode = 0;
    bit    gap_en     = 1'b0;
    bit    abort      = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail_tmo(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out, got no handshake, expected one (cycle %0d)", name, cycle);
    endtask

    // Expected output of one packet: header words MSB first, then payload with sop cleared.
    task automatic push_expected(input int k);
        beat_t b;
        for (int w = 0; w < HW; w++) begin
            b = '0;
            b.data = hdr[k][HS-1-w*DW -: DW];
            b.sop  = (w == 0);
            expq.push_back(b);
        end
        for (int j = 0; j < plen[k]; j++) begin
            b = '0;
            b.data  = pay[k][j];
            b.eop   = (j == plen[k] - 1);
            b.empty = pemp[k][j];
            expq.push_back(b);
        end
    endtask

    // Sink ready: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        s_out.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       s_out.ready = 1'b1;
                1:       s_out.ready = ~s_out.ready;
                default: s_out.ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Reference model and per-cycle comparison.
    initial begin : compare
        int          phase;
        int          hsent;
        logic [15:0] model_cnt;
        beat_t       e;
        beat_t       got;
        phase = 0;
        hsent = 0;
        model_cnt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
                hsent = 0;
                model_cnt = '0;
                expq.delete();
            end else begin
                chk("header_ready", DW'(header_ready), DW'(phase == 0));
                chk("in_ready", DW'(s_in.ready), DW'((phase == 2) ? s_out.ready : 1'b0));
                chk("out_valid", DW'(s_out.valid),
                    DW'((phase == 0) ? 1'b0 : (phase == 1) ? 1'b1 : s_in.valid));
`ifdef HEADER_INSERTER_PKT_CNT_EN
                chk("pkt_count", DW'(pkt_count), DW'(model_cnt));
`endif
                if (s_out.valid && s_out.ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_beat", DW'(1), DW'(0));
                    end else begin
                        e = expq.pop_front();
                        chk("beat_data", s_out.data, e.data);
                        chk("beat_sop", DW'(s_out.sop), DW'(e.sop));
                        chk("beat_eop", DW'(s_out.eop), DW'(e.eop));
                        chk("beat_empty", DW'(s_out.empty), DW'(e.empty));
                        got = '0;
                        got.data = s_out.data;
                        got.sop = s_out.sop;
                        got.eop = s_out.eop;
                        got.empty = s_out.empty;
                        got.cyc = cycle;
                        logq.push_back(got);
                    end
                end
                case (phase)
                    0: if (header_valid) begin
                        hs_cyc.push_back(int'(cycle));
                        phase = 1;
                        hsent = 0;
                    end
                    1: if (s_out.ready) begin
                        hsent++;
                        if (hsent == HW) phase = 2;
                    end
                    default: if (s_in.valid && s_out.ready && s_in.eop) begin
                        phase = 0;
                        model_cnt = model_cnt + 16'd1;
                    end
                endcase
            end
        end
    end

    task automatic drive_headers(input int a, input int b);
        bit hs;
        int n;
        for (int k = a; k <= b && !abort; k++) begin
            if (gap_en && $urandom_range(3) == 0) begin
                header_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            header_valid = 1'b1;
            header_data  = hdr[k];
            hs = 1'b0;
            n  = 0;
            while (!hs && !abort) begin
                @(negedge clk);
                hs = header_ready && !rst;
                @(posedge clk);
                #1;
                n++;
                if (!hs && n > TMO) begin
                    fail_tmo("header_handshake");
                    abort = 1'b1;
                end
            end
        end
        header_valid = 1'b0;
    endtask

    task automatic drive_payload(input int a, input int b);
        bit hs;
        int n;
        for (int k = a; k <= b && !abort; k++) begin
            for (int j = 0; j < plen[k] && !abort; j++) begin
                if (gap_en && $urandom_range(3) == 0) begin
                    s_in.valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                s_in.valid = 1'b1;
                s_in.data  = pay[k][j];
                s_in.sop   = (j == 0);
                s_in.eop   = (j == plen[k] - 1);
                s_in.empty = pemp[k][j];
                hs = 1'b0;
                n  = 0;
                while (!hs && !abort) begin
                    @(negedge clk);
                    hs = s_in.ready && !rst;
                    @(posedge clk);
                    #1;
                    n++;
                    if (!hs && n > TMO) begin
                        fail_tmo("payload_handshake");
                        abort = 1'b1;
                    end
                end
            end
        end
        s_in.valid = 1'b0;
        s_in.sop   = 1'b0;
        s_in.eop   = 1'b0;
    endtask

    task automatic run_pkts(input int a, input int b);
        int n;
        for (int k = a; k <= b; k++) push_expected(k);
        abort = 1'b0;
        fork
            drive_headers(a, b);
            drive_payload(a, b);
        join
        n = 0;
        while (expq.size() != 0 && n < TMO) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", DW'(expq.size()), DW'(0));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int hb;
        int e;
        int n;
        int k;

        s_in.valid = 1'b0;
        s_in.data  = '0;
        s_in.sop   = 1'b0;
        s_in.eop   = 1'b0;
        s_in.empty = '0;

        for (int p = 0; p < NPK; p++) begin
            for (int i = 0; i < HS / 32; i++) hdr[p][i*32 +: 32] = $urandom();
            for (int j = 0; j < MAXP; j++) begin
                for (int i = 0; i < DW / 32; i++) pay[p][j][i*32 +: 32] = $urandom();
                pemp[p][j] = 4'($urandom_range(15));
            end
            plen[p] = $urandom_range(1, MAXP);
        end
        hdr[0] = {{4{32'hAAAAAAAA}}, {4{32'hBBBBBBBB}}};
        plen[0] = 3;
        pay[0][0] = {4{32'hC0DE0000}};
        pay[0][1] = {4{32'hC0DE0001}};
        pay[0][2] = {4{32'hC0DE0002}};
        pemp[0][2] = 4'd3;
        hdr[1] = hdr[0];
        plen[1] = 2;
        hdr[2] = hdr[0];
        plen[2] = 1;
        pay[2][0] = {4{32'h5EEDF00D}};
        pemp[2][0] = 4'd5;
        plen[NPK-2] = 3;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_header_ready", DW'(header_ready), DW'(0));
        chk("rst_out_valid", DW'(s_out.valid), DW'(0));
        chk("rst_out_sop", DW'(s_out.sop), DW'(0));
        chk("rst_out_eop", DW'(s_out.eop), DW'(0));
        chk("rst_out_empty", DW'(s_out.empty), DW'(0));
        chk("rst_out_data", s_out.data, '0);
        chk("rst_in_ready", DW'(s_in.ready), DW'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_header_ready", DW'(header_ready), DW'(1));

        // Two-word header, three-word payload, sink always ready
        ready_mode = 0;
        gap_en = 1'b0;
        run_pkts(0, 0);
        chk("p0_w0_data", logq[0].data, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA);
        chk("p0_w0_sop", DW'(logq[0].sop), DW'(1));
        chk("p0_w1_data", logq[1].data, 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB);
        chk("p0_w1_sop", DW'(logq[1].sop), DW'(0));
        chk("p0_w2_data", logq[2].data, 128'hC0DE0000_C0DE0000_C0DE0000_C0DE0000);
        chk("p0_w4_data", logq[4].data, 128'hC0DE0002_C0DE0002_C0DE0002_C0DE0002);
        chk("p0_w4_eop", DW'(logq[4].eop), DW'(1));
        chk("p0_w4_empty", DW'(logq[4].empty), DW'(3));
        chk("p0_latency", DW'(logq[0].cyc), DW'(hs_cyc[0] + 1));
        chk("p0_span", DW'(logq[4].cyc), DW'(logq[0].cyc + 4));

        // Same header with toggling sink ready
        base = logq.size();
        ready_mode = 1;
        run_pkts(1, 1);
        chk("p1_w0_data", logq[base].data, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA);
        chk("p1_w1_data", logq[base+1].data, 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB);

        // Single-word payload with empty=5
        base = logq.size();
        ready_mode = 0;
        run_pkts(2, 2);
        chk("p2_w2_data", logq[base+2].data, 128'h5EEDF00D_5EEDF00D_5EEDF00D_5EEDF00D);
        chk("p2_w2_eop", DW'(logq[base+2].eop), DW'(1));
        chk("p2_w2_empty", DW'(logq[base+2].empty), DW'(5));
        chk("p2_w2_sop", DW'(logq[base+2].sop), DW'(0));
`ifdef HEADER_INSERTER_PKT_CNT_EN
        chk("pkt_count_3", DW'(pkt_count), DW'(3));
`endif

        // Back-to-back with header_valid held high
        base = logq.size();
        hb = hs_cyc.size();
        run_pkts(3, 4);
        e = base + HW + plen[3] - 1;
        chk("b2b_h2_capture", DW'(hs_cyc[hb+1]), DW'(logq[e].cyc + 1));
        chk("b2b_h2_sop", DW'(logq[e+1].sop), DW'(1));
        chk("b2b_h2_data", logq[e+1].data, hdr[4][HS-1 -: DW]);

        // Randomized traffic
        ready_mode = 2;
        gap_en = 1'b1;
        run_pkts(5, NPK - 3);

        // Reset during the second payload word
        ready_mode = 0;
        gap_en = 1'b0;
        k = NPK - 2;
        push_expected(k);
        abort = 1'b0;
        base = logq.size();
        fork
            drive_headers(k, k);
            drive_payload(k, k);
            begin
                n = 0;
                while (logq.size() < base + HW + 1 && n < TMO) begin
                    @(posedge clk);
                    n++;
                end
                if (logq.size() < base + HW + 1) fail_tmo("reset_setup");
                @(negedge clk);
                #1;
                chk("pre_rst_valid", DW'(s_out.valid), DW'(1));
                chk("pre_rst_data", s_out.data, pay[k][1]);
                rst = 1'b1;
                #1;
                chk("mid_rst_valid", DW'(s_out.valid), DW'(0));
                chk("mid_rst_header_ready", DW'(header_ready), DW'(0));
                chk("mid_rst_in_ready", DW'(s_in.ready), DW'(0));
                abort = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", DW'(header_ready), DW'(1));
        chk("post_rst_valid", DW'(s_out.valid), DW'(0));

        // Clean packet after reset
        base = logq.size();
        run_pkts(NPK - 1, NPK - 1);
        chk("post_rst_sop", DW'(logq[base].sop), DW'(1));
        chk("post_rst_data", logq[base].data, hdr[NPK-1][HS-1 -: DW]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
